reg_file_param: RTL and testbench

//   Parametrised 2-read / 2-write register file for the 16-bit CPU datapath; successor to the fixed 4x16 file.

---
 rtl/reg_file_param_if.sv | 32 +++
 rtl/reg_file_param.sv | 77 +++++++
 tb/tb_reg_file_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: decode read/reserve ports plus the two writeback ports.
interface reg_file_param_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
);
    localparam int AW = $clog2(NUM_REGS);

    logic [AW-1:0]     RS;
    logic [AW-1:0]     RT;
    logic [DATA_W-1:0] ReadRS;
    logic [DATA_W-1:0] ReadRT;
    logic              BusyRS;
    logic              BusyRT;
    logic              WrEnA;
    logic [AW-1:0]     WrAddrA;
    logic [DATA_W-1:0] WrDataA;
    logic              WrEnB;
    logic [AW-1:0]     WrAddrB;
    logic [DATA_W-1:0] WrDataB;
    logic              ResvEn;
    logic [AW-1:0]     ResvAddr;

    modport master (
        output RS, RT, WrEnA, WrAddrA, WrDataA, WrEnB, WrAddrB, WrDataB, ResvEn, ResvAddr,
        input  ReadRS, ReadRT, BusyRS, BusyRT
    );

    modport slave (
        input  RS, RT, WrEnA, WrAddrA, WrDataA, WrEnB, WrAddrB, WrDataB, ResvEn, ResvAddr,
        output ReadRS, ReadRT, BusyRS, BusyRT
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2-read / 2-write register file with hardwired zero register,
// optional write-to-read bypass and per-register busy scoreboard bits.
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    reg_file_param_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                drop_a;
    logic                drop_b;
    logic [AW-1:0]       raddr [2];
    logic [DATA_W-1:0]   rdata [2];
    logic                rbusy [2];

    assign drop_a = (ZERO_REG != 0) && (bus.WrAddrA == '0);
    assign drop_b = (ZERO_REG != 0) && (bus.WrAddrB == '0);

    // Writes retire the producer; a reserve in the same cycle belongs to a newer producer, so it wins.
    always_comb begin
        busy_next = busy;
        if (bus.WrEnA) busy_next[bus.WrAddrA] = 1'b0;
        if (bus.WrEnB) busy_next[bus.WrAddrB] = 1'b0;
        if (bus.ResvEn) busy_next[bus.ResvAddr] = 1'b1;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    // Port B is written last so the load result wins an address collision.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            busy <= busy_next;
            if (bus.WrEnA && !drop_a) regs[bus.WrAddrA] <= bus.WrDataA;
            if (bus.WrEnB && !drop_b) regs[bus.WrAddrB] <= bus.WrDataB;
        end
    end

    assign raddr[0] = bus.RS;
    assign raddr[1] = bus.RT;

    // A bypassed write also hides the busy bit, since decode can consume the forwarded value now.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic hit_a;
            logic hit_b;
            hit_a    = (BYPASS != 0) && bus.WrEnA && (bus.WrAddrA == raddr[p]);
            hit_b    = (BYPASS != 0) && bus.WrEnB && (bus.WrAddrB == raddr[p]);
            rdata[p] = regs[raddr[p]];
            if (hit_a) rdata[p] = bus.WrDataA;
            if (hit_b) rdata[p] = bus.WrDataB;
            rbusy[p] = busy[raddr[p]] & ~(hit_a | hit_b);
            if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
            if (!Reset_n) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.ReadRS = rdata[0];
    assign bus.ReadRT = rdata[1];
    assign bus.BusyRS = rbusy[0];
    assign bus.BusyRT = rbusy[1];
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed vector table on the default and no-bypass
// builds, hand-written reset sequence, and a 32-bit x 16 build run against a reference model.
module tb_reg_file_param;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg_file_param_if #(.DATA_W(16), .NUM_REGS(4))  if0 ();
    reg_file_param_if #(.DATA_W(16), .NUM_REGS(4))  if1 ();
    reg_file_param_if #(.DATA_W(32), .NUM_REGS(16)) if2 ();

    reg_file_param #(.DATA_W(16), .NUM_REGS(4), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .Clock(clk), .Reset_n(rst_n), .bus(if0)
    );
    reg_file_param #(.DATA_W(16), .NUM_REGS(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .Clock(clk), .Reset_n(rst_n), .bus(if1)
    );
    reg_file_param #(.DATA_W(32), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1)) dut2 (
        .Clock(clk), .Reset_n(rst_n), .bus(if2)
    );

    // The no-bypass build sees exactly the same traffic as the default build.
    assign if1.RS       = if0.RS;
    assign if1.RT       = if0.RT;
    assign if1.WrEnA    = if0.WrEnA;
    assign if1.WrAddrA  = if0.WrAddrA;
    assign if1.WrDataA  = if0.WrDataA;
    assign if1.WrEnB    = if0.WrEnB;
    assign if1.WrAddrB  = if0.WrAddrB;
    assign if1.WrDataB  = if0.WrDataB;
    assign if1.ResvEn   = if0.ResvEn;
    assign if1.ResvAddr = if0.ResvAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wa;
        logic [1:0]  aa;
        logic [15:0] da;
        logic        wb;
        logic [1:0]  ab;
        logic [15:0] db;
        logic        rv;
        logic [1:0]  ra;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [15:0] e_rs;
        logic [15:0] e_rt;
        logic        e_brs;
        logic        e_brt;
        logic [15:0] e1_rs;
        logic        e1_brs;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic wa, input logic [1:0] aa, input logic [15:0] da,
        input logic wb, input logic [1:0] ab, input logic [15:0] db,
        input logic rv, input logic [1:0] ra,
        input logic [1:0] rs, input logic [1:0] rt,
        input logic [15:0] e_rs, input logic [15:0] e_rt,
        input logic e_brs, input logic e_brt,
        input logic [15:0] e1_rs, input logic e1_brs
    );
        vec_t v;
        v.wa = wa; v.aa = aa; v.da = da;
        v.wb = wb; v.ab = ab; v.db = db;
        v.rv = rv; v.ra = ra; v.rs = rs; v.rt = rt;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_brs = e_brs; v.e_brt = e_brt;
        v.e1_rs = e1_rs; v.e1_brs = e1_brs;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        if0.WrEnA    = v.wa;
        if0.WrAddrA  = v.aa;
        if0.WrDataA  = v.da;
        if0.WrEnB    = v.wb;
        if0.WrAddrB  = v.ab;
        if0.WrDataB  = v.db;
        if0.ResvEn   = v.rv;
        if0.ResvAddr = v.ra;
        if0.RS       = v.rs;
        if0.RT       = v.rt;
        #1;
    endtask

    task automatic idleBus0();
        if0.WrEnA = 1'b0; if0.WrAddrA = '0; if0.WrDataA = '0;
        if0.WrEnB = 1'b0; if0.WrAddrB = '0; if0.WrDataB = '0;
        if0.ResvEn = 1'b0; if0.ResvAddr = '0;
    endtask

    // Reference model for the 32-bit x 16 build.
    logic [31:0] m_regs [16];
    logic        m_busy [16];

    initial begin
        logic        wa, wb, rv;
        logic [3:0]  aa, ab, ra, rs, rt;
        logic [31:0] da, db, e_rs, e_rt;
        logic        e_brs, e_brt;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idleBus0();
        if0.RS = '0; if0.RT = '0;
        if2.RS = '0; if2.RT = '0;
        if2.WrEnA = 1'b0; if2.WrAddrA = '0; if2.WrDataA = '0;
        if2.WrEnB = 1'b0; if2.WrAddrB = '0; if2.WrDataB = '0;
        if2.ResvEn = 1'b0; if2.ResvAddr = '0;

        //          wa aa da       wb ab db       rv ra rs rt e_rs     e_rt     brs brt e1_rs    e1_brs
        vecs[0]  = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        vecs[1]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 1, 2, 16'h1111, 16'h2222, 0, 0, 16'h0000, 0);
        vecs[2]  = mk(1, 3, 16'h3333, 0, 0, 16'h0,    0, 0, 1, 2, 16'h1111, 16'h2222, 0, 0, 16'h1111, 0);
        vecs[3]  = mk(1, 0, 16'hBEEF, 0, 0, 16'h0,    0, 0, 0, 3, 16'h0000, 16'h3333, 0, 0, 16'h0000, 0);
        vecs[4]  = mk(0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        vecs[5]  = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 3, 16'h0000, 16'h3333, 0, 0, 16'h0000, 0);
        vecs[6]  = mk(1, 2, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 2, 2, 16'h5555, 16'h5555, 0, 0, 16'h2222, 0);
        vecs[7]  = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 2, 16'h1111, 16'h5555, 0, 0, 16'h1111, 0);
        vecs[8]  = mk(1, 1, 16'h0001, 1, 3, 16'h0003, 0, 0, 1, 3, 16'h0001, 16'h0003, 0, 0, 16'h1111, 0);
        vecs[9]  = mk(1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 3, 1, 16'h1234, 16'h0001, 0, 0, 16'h0003, 0);
        vecs[10] = mk(0, 0, 16'h0,    0, 0, 16'h0,    1, 1, 3, 1, 16'h1234, 16'h0001, 0, 0, 16'h1234, 0);
        vecs[11] = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 2, 16'h0001, 16'h5555, 1, 0, 16'h0001, 1);
        vecs[12] = mk(0, 0, 16'h0,    1, 1, 16'h00FF, 0, 0, 1, 1, 16'h00FF, 16'h00FF, 0, 0, 16'h0001, 1);
        vecs[13] = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 3, 16'h00FF, 16'h1234, 0, 0, 16'h00FF, 0);
        vecs[14] = mk(1, 1, 16'h0BAD, 0, 0, 16'h0,    1, 1, 1, 0, 16'h0BAD, 16'h0000, 0, 0, 16'h00FF, 0);
        vecs[15] = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 16'h0BAD, 16'h0BAD, 1, 1, 16'h0BAD, 1);
        vecs[16] = mk(0, 0, 16'h0,    0, 0, 16'h0,    1, 1, 1, 1, 16'h0BAD, 16'h0BAD, 1, 1, 16'h0BAD, 1);
        vecs[17] = mk(1, 2, 16'h7777, 0, 0, 16'h0,    0, 0, 1, 2, 16'h0BAD, 16'h7777, 1, 0, 16'h0BAD, 1);
        vecs[18] = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 1, 16'h7777, 16'h0BAD, 0, 1, 16'h7777, 0);
        vecs[19] = mk(1, 1, 16'h4444, 0, 0, 16'h0,    1, 2, 1, 2, 16'h4444, 16'h7777, 0, 0, 16'h0BAD, 1);
        vecs[20] = mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 2, 16'h4444, 16'h7777, 0, 1, 16'h4444, 0);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("held_reset_rs", 32'(if0.ReadRS), 32'h0);
        checkOutput("held_reset_busy", 32'(if0.BusyRS), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_read_rs", i), 32'(if0.ReadRS), 32'(vecs[i].e_rs));
            checkOutput($sformatf("v%0d_read_rt", i), 32'(if0.ReadRT), 32'(vecs[i].e_rt));
            checkOutput($sformatf("v%0d_busy_rs", i), 32'(if0.BusyRS), 32'(vecs[i].e_brs));
            checkOutput($sformatf("v%0d_busy_rt", i), 32'(if0.BusyRT), 32'(vecs[i].e_brt));
            checkOutput($sformatf("v%0d_nobyp_rs", i), 32'(if1.ReadRS), 32'(vecs[i].e1_rs));
            checkOutput($sformatf("v%0d_nobyp_busy", i), 32'(if1.BusyRS), 32'(vecs[i].e1_brs));
        end

        // Mid-cycle asynchronous reset: outputs must drop without waiting for a clock edge.
        @(negedge clk);
        idleBus0();
        if0.RS = 2'd1;
        if0.RT = 2'd2;
        #1;
        checkOutput("pre_reset_rs", 32'(if0.ReadRS), 32'h4444);
        checkOutput("pre_reset_busy_rt", 32'(if0.BusyRT), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rs", 32'(if0.ReadRS), 32'h0);
        checkOutput("async_reset_rt", 32'(if0.ReadRT), 32'h0);
        checkOutput("async_reset_busy_rt", 32'(if0.BusyRT), 32'h0);
        if0.WrEnA   = 1'b1;
        if0.WrAddrA = 2'd1;
        if0.WrDataA = 16'h9999;
        #1;
        checkOutput("reset_blocks_bypass", 32'(if0.ReadRS), 32'h0);
        @(negedge clk);
        idleBus0();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_reset_rs", 32'(if0.ReadRS), 32'h0);
        checkOutput("post_reset_rt", 32'(if0.ReadRT), 32'h0);
        checkOutput("post_reset_busy_rt", 32'(if0.BusyRT), 32'h0);
        checkOutput("post_reset_nobyp_rs", 32'(if1.ReadRS), 32'h0);

        // Wide build: top register write and read-back, then randomized traffic against the model.
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        if2.WrEnA   = 1'b1;
        if2.WrAddrA = 4'd15;
        if2.WrDataA = 32'hDEADBEEF;
        @(negedge clk);
        if2.WrEnA = 1'b0;
        if2.RS    = 4'd15;
        if2.RT    = 4'd0;
        m_regs[15] = 32'hDEADBEEF;
        #1;
        checkOutput("wide_r15", if2.ReadRS, 32'hDEADBEEF);
        checkOutput("wide_r0", if2.ReadRT, 32'h0);

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            wa = ($urandom_range(0, 1) == 1);
            wb = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 2) == 0);
            aa = 4'($urandom_range(0, 15));
            ab = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rs = 4'($urandom_range(0, 15));
            rt = 4'($urandom_range(0, 15));
            da = $urandom;
            db = $urandom;
            if2.WrEnA = wa; if2.WrAddrA = aa; if2.WrDataA = da;
            if2.WrEnB = wb; if2.WrAddrB = ab; if2.WrDataB = db;
            if2.ResvEn = rv; if2.ResvAddr = ra;
            if2.RS = rs; if2.RT = rt;
            #1;
            e_rs  = (rs == 0) ? 32'h0 : (wb && ab == rs) ? db : (wa && aa == rs) ? da : m_regs[rs];
            e_rt  = (rt == 0) ? 32'h0 : (wb && ab == rt) ? db : (wa && aa == rt) ? da : m_regs[rt];
            e_brs = (rs != 0) && m_busy[rs] && !((wa && aa == rs) || (wb && ab == rs));
            e_brt = (rt != 0) && m_busy[rt] && !((wa && aa == rt) || (wb && ab == rt));
            checkOutput($sformatf("rnd%0d_read_rs", c), if2.ReadRS, e_rs);
            checkOutput($sformatf("rnd%0d_read_rt", c), if2.ReadRT, e_rt);
            checkOutput($sformatf("rnd%0d_busy_rs", c), 32'(if2.BusyRS), 32'(e_brs));
            checkOutput($sformatf("rnd%0d_busy_rt", c), 32'(if2.BusyRT), 32'(e_brt));
            if (wa && aa != 0) m_regs[aa] = da;
            if (wb && ab != 0) m_regs[ab] = db;
            if (wa) m_busy[aa] = 1'b0;
            if (wb) m_busy[ab] = 1'b0;
            if (rv && ra != 0) m_busy[ra] = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
